dm_wb_cache: RTL

- Direct-mapped, write-back, write-allocate cache between the pipelined datapath's 32-bit cache port and a 256-bit line-granular physical memory port.
- Two instances are planned, one for I-side and one for D-side. The CPU side uses the same address/read/write/wdata/mbe/resp/rdata contract the datapath drives.
- A miss stalls the requester by withholding resp, with optional writeback of a dirty victim followed by line fill.

---
 rtl/dm_wb_cache.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate cache: 32-bit CPU word port in front of a
// 256-bit line-granular memory port. A miss stalls the requester, optionally writes back a dirty victim, then fills.
module dm_wb_cache #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_mbe,
    output logic         mem_resp,
    output logic [31:0]  mem_rdata,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {CHECK, RESP, WRITEBACK, FILL} state_t;

    state_t               state_q, state_d;
    logic                 mem_resp_q, mem_resp_d;
    logic [31:0]          mem_rdata_q, mem_rdata_d;
    logic [31:0]          pmem_address_q, pmem_address_d;
    logic                 pmem_read_q, pmem_read_d;
    logic                 pmem_write_q, pmem_write_d;
    logic [255:0]         pmem_wdata_q, pmem_wdata_d;

    logic                 valid_q [SETS];
    logic                 dirty_q [SETS];
    logic [TAG_W-1:0]     tag_q   [SETS];
    logic [255:0]         data_q  [SETS];

    logic                 set_we;
    logic                 valid_d, dirty_d;
    logic [TAG_W-1:0]     tag_d;
    logic [255:0]         data_d;

    logic [S_INDEX-1:0]   idx;
    logic [TAG_W-1:0]     tag_in;
    logic [2:0]           wsel;
    logic                 req, is_write, hit;
    logic [255:0]         line_cur, line_merged;
    logic                 unused_addr_bits;

    assign idx              = mem_address[4+S_INDEX:5];
    assign tag_in           = mem_address[31:5+S_INDEX];
    assign wsel             = mem_address[4:2];
    assign unused_addr_bits = ^mem_address[1:0];
    assign req              = mem_read | mem_write;
    assign is_write         = mem_write;
    assign line_cur         = data_q[idx];
    assign hit              = valid_q[idx] && (tag_q[idx] == tag_in);

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign pmem_address = pmem_address_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_wdata   = pmem_wdata_q;

    // Byte-lane merge of the CPU write word into the currently indexed line.
    always_comb begin
        line_merged = line_cur;
        for (int b = 0; b < 4; b++) begin
            if (mem_mbe[b]) begin
                line_merged[(32 * int'(wsel)) + (8 * b) +: 8] = mem_wdata[8 * b +: 8];
            end else begin
                line_merged[(32 * int'(wsel)) + (8 * b) +: 8] = line_cur[(32 * int'(wsel)) + (8 * b) +: 8];
            end
        end
    end

    // Next-state, next-output and single-set array update computation.
    always_comb begin
        state_d        = state_q;
        mem_resp_d     = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        pmem_address_d = pmem_address_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_wdata_d   = pmem_wdata_q;
        set_we         = 1'b0;
        data_d         = line_cur;
        tag_d          = tag_q[idx];
        valid_d        = valid_q[idx];
        dirty_d        = dirty_q[idx];
        case (state_q)
            CHECK: begin
                pmem_read_d    = 1'b0;
                pmem_write_d   = 1'b0;
                pmem_address_d = 32'h0000_0000;
                pmem_wdata_d   = 256'd0;
                if (req && hit) begin
                    state_d    = RESP;
                    mem_resp_d = 1'b1;
                    if (is_write) begin
                        set_we  = 1'b1;
                        data_d  = line_merged;
                        dirty_d = dirty_q[idx] | (|mem_mbe);
                    end else begin
                        mem_rdata_d = line_cur[32 * int'(wsel) +: 32];
                    end
                end else if (req && valid_q[idx] && dirty_q[idx]) begin
                    state_d        = WRITEBACK;
                    pmem_write_d   = 1'b1;
                    pmem_address_d = {tag_q[idx], idx, 5'b00000};
                    pmem_wdata_d   = line_cur;
                end else if (req) begin
                    state_d        = FILL;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = {mem_address[31:5], 5'b00000};
                end else begin
                    state_d = CHECK;
                end
            end
            RESP: begin
                state_d = CHECK;
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    set_we         = 1'b1;
                    dirty_d        = 1'b0;
                    state_d        = FILL;
                    pmem_write_d   = 1'b0;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = {mem_address[31:5], 5'b00000};
                end else begin
                    state_d = WRITEBACK;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    set_we         = 1'b1;
                    data_d         = pmem_rdata;
                    tag_d          = tag_in;
                    valid_d        = 1'b1;
                    dirty_d        = 1'b0;
                    pmem_read_d    = 1'b0;
                    pmem_address_d = 32'h0000_0000;
                    state_d        = CHECK;
                end else begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = CHECK;
            end
        endcase
    end

    // State, registered outputs and the cache arrays; reset blocks any array write in its cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CHECK;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= 32'h0000_0000;
            pmem_address_q <= 32'h0000_0000;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_wdata_q   <= 256'd0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 1'b0;
                dirty_q[s] <= 1'b0;
            end
        end else begin
            state_q        <= state_d;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            pmem_address_q <= pmem_address_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_wdata_q   <= pmem_wdata_d;
            if (set_we) begin
                valid_q[idx] <= valid_d;
                dirty_q[idx] <= dirty_d;
                tag_q[idx]   <= tag_d;
                data_q[idx]  <= data_d;
            end
        end
    end

endmodule
